// File: rtl/gb_mem_pkg.sv
// Shared memory-map types and constants for the Game Boy bus blocks.
// Also provides the echo-RAM source mapping used by OAM DMA.
package gb_mem_pkg;

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} dma_state_t;
  typedef enum logic [1:0] {REG_EXT, REG_HRAM, REG_DMA} region_t;

  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] HRAM_LO      = 16'hFF80;
  localparam logic [15:0] HRAM_HI      = 16'hFFFE;

  // Sources at E0xx and above alias work RAM 0x2000 lower.
  function automatic logic [7:0] dma_eff_src(input logic [7:0] src);
    return (src >= 8'hE0) ? (src - 8'h20) : src;
  endfunction

endpackage

// File: rtl/mem_region_decode.sv
// Combinational CPU address -> region classifier (DMA register, HRAM, external bus).
module mem_region_decode
  import gb_mem_pkg::*;
(
  input  logic [15:0] addr,
  output region_t     region
);

  always_comb begin
    region = REG_EXT;
    if (addr == DMA_REG_ADDR) begin
      region = REG_DMA;
    end else if (addr >= HRAM_LO && addr <= HRAM_HI) begin
      region = REG_HRAM;
    end
  end

endmodule

// File: rtl/oam_dma_arbiter.sv
// Shared-bus arbiter between the CPU and the OAM DMA engine (FF46).
// Define OAM_DMA_RESTART_EN to let an FF46 write during a transfer restart it.
module oam_dma_arbiter
  import gb_mem_pkg::*;
#(
  parameter int          OAM_LEN       = 160,
  parameter int          START_DELAY   = 1,
  parameter logic [7:0]  LOCKOUT_RDATA = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic [7:0]  hram_wdata,
  output logic        hram_we,
  input  logic [7:0]  hram_rdata,
  output logic        dma_active
);

  localparam logic [7:0] LAST_IDX    = 8'(OAM_LEN - 1);
  localparam dma_state_t FIRST_STATE = (START_DELAY == 0) ? READ : START;

  dma_state_t  state_q, state_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  buf_q, buf_d;
  logic [1:0]  dly_q, dly_d;
  logic        dma_active_q, dma_active_d;
  region_t     region;
  logic        dma_reg_wr;

  mem_region_decode u_decode (
    .addr   (cpu_addr),
    .region (region)
  );

  assign dma_reg_wr = cpu_we && (region == REG_DMA);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    dly_d   = dly_q;
    case (state_q)
      IDLE: begin
        if (dma_reg_wr) begin
          src_d   = cpu_wdata;
          idx_d   = 8'h00;
          dly_d   = 2'd0;
          state_d = FIRST_STATE;
        end
      end
      START: begin
        if (int'(dly_q) + 1 >= START_DELAY) begin
          state_d = READ;
        end else begin
          dly_d = dly_q + 2'd1;
        end
      end
      READ: begin
        buf_d   = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef OAM_DMA_RESTART_EN
    if (state_q != IDLE && dma_reg_wr) begin
      src_d   = cpu_wdata;
      idx_d   = 8'h00;
      dly_d   = 2'd0;
      buf_d   = 8'h00;
      state_d = FIRST_STATE;
    end
`endif
    dma_active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      src_q        <= 8'h00;
      idx_q        <= 8'h00;
      buf_q        <= 8'h00;
      dly_q        <= 2'd0;
      dma_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      idx_q        <= idx_d;
      buf_q        <= buf_d;
      dly_q        <= dly_d;
      dma_active_q <= dma_active_d;
    end
  end

  // Bus outputs are forced quiet while reset is held, independent of the clock.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_wdata = 8'h00;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    if (rst) begin
      case (state_q)
        IDLE: begin
          if (region == REG_EXT) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = cpu_we;
            mem_re    = cpu_re && !cpu_we;
          end
        end
        READ: begin
          mem_addr = {dma_eff_src(src_q), idx_q};
          mem_re   = 1'b1;
        end
        WRITE: begin
          mem_addr  = OAM_BASE + {8'h00, idx_q};
          mem_wdata = buf_q;
          mem_we    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (region)
      REG_HRAM: cpu_rdata = hram_rdata;
      REG_DMA:  cpu_rdata = src_q;
      default:  cpu_rdata = (state_q == IDLE) ? mem_rdata : LOCKOUT_RDATA;
    endcase
  end

  assign hram_addr  = cpu_addr[6:0];
  assign hram_wdata = cpu_wdata;
  assign hram_we    = rst && cpu_we && (region == REG_HRAM);
  assign dma_active = dma_active_q;

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Self-checking bench for oam_dma_arbiter: directed DMA scenarios with random source data,
// expectations from a flat memory shadow. Restart expectations follow OAM_DMA_RESTART_EN.
module tb_oam_dma_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_re = 1'b0;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_re;
  logic        mem_we;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_we;
  logic [7:0]  hram_rdata;
  logic        dma_active;

  logic [7:0]  mem_arr  [0:65535];
  logic [7:0]  hram_arr [0:127];
  logic [7:0]  shadow   [0:65535];
  logic [15:0] rd_log   [0:1023];

  int vectors = 0;
  int miscompares = 0;
  int act_cnt = 0;
  int viol_cnt = 0;
  int rd_total = 0;

  oam_dma_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_re     (cpu_re),
    .cpu_we     (cpu_we),
    .cpu_rdata  (cpu_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_re     (mem_re),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata),
    .hram_addr  (hram_addr),
    .hram_wdata (hram_wdata),
    .hram_we    (hram_we),
    .hram_rdata (hram_rdata),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  assign mem_rdata  = mem_arr[mem_addr];
  assign hram_rdata = hram_arr[hram_addr];

  always @(posedge clk) begin
    if (mem_we)  mem_arr[mem_addr]   <= mem_wdata;
    if (hram_we) hram_arr[hram_addr] <= hram_wdata;
  end

  // Bus monitor: sampled at the active edge, before the design updates.
  always @(posedge clk) begin
    if (dma_active) act_cnt <= act_cnt + 1;
    if (mem_re && mem_we) viol_cnt <= viol_cnt + 1;
    if (mem_we && mem_addr >= 16'hFF80 && mem_addr <= 16'hFFFE) viol_cnt <= viol_cnt + 1;
    if (dma_active && mem_we && !(mem_addr >= 16'hFE00 && mem_addr < 16'hFEA0)) viol_cnt <= viol_cnt + 1;
    if (dma_active && mem_re) begin
      rd_log[rd_total % 1024] <= mem_addr;
      rd_total <= rd_total + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_re = 1'b0;
    @(negedge clk);
    cpu_we = 1'b0;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    cpu_write(a, d);
    shadow[a] = d;
  endtask

  task automatic cpu_read(input logic [15:0] a, output logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_re = 1'b1; cpu_we = 1'b0;
    #1 d = cpu_rdata;
    cpu_re = 1'b0;
  endtask

  task automatic clear_oam();
    for (int i = 0; i < 160; i++) poke(16'hFE00 + 16'(i), 8'h00);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (dma_active && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 2000), 32'd1);
  endtask

  task automatic wait_read(input logic [15:0] a, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!(mem_re && mem_addr == a) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 1000), 32'd1);
  endtask

  function automatic logic [7:0] eff_src(input logic [7:0] s);
    int v;
    v = int'(s);
    if (v >= 224) v = v - 32;
    return 8'(v);
  endfunction

  task automatic check_oam(input logic [7:0] s, input string tag);
    logic [15:0] base;
    base = {eff_src(s), 8'h00};
    for (int i = 0; i < 160; i++)
      chk(tag, 32'(mem_arr[16'hFE00 + 16'(i)]), 32'(shadow[base + 16'(i)]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  d;
    logic [15:0] a;
    int t0, r0;

    // Reset with a live CPU request on the bus: outputs must be quiet.
    cpu_addr = 16'hC123; cpu_wdata = 8'hA5; cpu_we = 1'b1;
    #1 rst = 1'b0;
    #1;
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_dma_active", 32'(dma_active), 32'd0);
    cpu_we = 1'b0; cpu_addr = 16'h0000;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    cpu_read(16'hFF46, d);
    chk("ff46_reset_val", 32'(d), 32'h00);

    // Idle traffic is forwarded to the external bus.
    poke(16'hC000, 8'h42);
    @(negedge clk);
    cpu_addr = 16'hC000; cpu_re = 1'b1;
    #1 chk("idle_mem_re", 32'(mem_re), 32'd1);
    chk("idle_mem_addr", 32'(mem_addr), 32'hC000);
    chk("idle_rd", 32'(cpu_rdata), 32'h42);
    cpu_re = 1'b0;
    for (int k = 0; k < 8; k++) begin
      a = 16'hA000 + 16'($urandom_range(0, 16'h1FFF));
      d = 8'($urandom);
      poke(a, d);
      cpu_read(a, d);
      chk("idle_rand_rd", 32'(d), 32'(shadow[a]));
    end

    // DMA from C1 with a known pattern, CPU activity during the transfer.
    for (int i = 0; i < 160; i++) poke(16'hC100 + 16'(i), 8'(i) ^ 8'h5A);
    clear_oam();
    t0 = act_cnt; r0 = rd_total;
    cpu_write(16'hFF46, 8'hC1);
    #1 chk("a_active_start", 32'(dma_active), 32'd1);
    chk("a_start_no_re", 32'(mem_re), 32'd0);
    chk("a_start_no_we", 32'(mem_we), 32'd0);
    @(negedge clk); #1;
    chk("a_first_re", 32'(mem_re), 32'd1);
    chk("a_first_raddr", 32'(mem_addr), 32'hC100);
    @(negedge clk); #1;
    chk("a_first_we", 32'(mem_we), 32'd1);
    chk("a_first_waddr", 32'(mem_addr), 32'hFE00);
    chk("a_first_wdata", 32'(mem_wdata), 32'h5A);
    @(negedge clk);
    cpu_addr = 16'hFF90; cpu_wdata = 8'h77; cpu_we = 1'b1;
    #1 chk("a_hram_we", 32'(hram_we), 32'd1);
    @(negedge clk);
    cpu_we = 1'b0; cpu_re = 1'b1;
    #1 chk("a_hram_rd", 32'(cpu_rdata), 32'h77);
    @(negedge clk);
    cpu_addr = 16'hC000;
    #1 chk("a_lockout_rd", 32'(cpu_rdata), 32'hFF);
    chk("a_no_cpu_re", 32'(mem_re && mem_addr == 16'hC000), 32'd0);
    @(negedge clk);
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_wdata = 8'h33;
    #1 chk("a_no_cpu_we", 32'(mem_we && mem_addr == 16'hC000), 32'd0);
    cpu_read(16'hFF46, d);
    chk("a_ff46_during", 32'(d), 32'hC1);
    wait_done("a_done_timeout");
    chk("a_active_cycles", 32'(act_cnt - t0), 32'd321);
    chk("a_read_count", 32'(rd_total - r0), 32'd160);
    for (int i = 0; i < 160; i++)
      chk("a_read_addr", 32'(rd_log[(r0 + i) % 1024]), 32'hC100 + 32'(i));
    check_oam(8'hC1, "a_oam");
    chk("a_dropped_write", 32'(mem_arr[16'hC000]), 32'h42);
    cpu_read(16'hFF46, d);
    chk("a_ff46_after", 32'(d), 32'hC1);

    // Echo-RAM source: E2 reads from C2xx.
    for (int i = 0; i < 160; i++) poke(16'hC200 + 16'(i), 8'($urandom));
    clear_oam();
    t0 = act_cnt; r0 = rd_total;
    cpu_write(16'hFF46, 8'hE2);
    wait_done("e_done_timeout");
    chk("e_active_cycles", 32'(act_cnt - t0), 32'd321);
    for (int i = 0; i < 160; i++)
      chk("e_read_addr", 32'(rd_log[(r0 + i) % 1024]), 32'hC200 + 32'(i));
    check_oam(8'hE2, "e_oam");

    // Second FF46 write arrives during the byte-40 read.
    for (int i = 0; i < 160; i++) poke(16'hD000 + 16'(i), 8'($urandom));
    clear_oam();
    t0 = act_cnt;
    cpu_write(16'hFF46, 8'hC1);
    wait_read(16'hC128, "r_wait_byte40");
    cpu_addr = 16'hFF46; cpu_wdata = 8'hD0; cpu_we = 1'b1;
    @(negedge clk);
    cpu_we = 1'b0;
    wait_done("r_done_timeout");
    cpu_read(16'hFF46, d);
`ifdef OAM_DMA_RESTART_EN
    chk("r_active_cycles", 32'(act_cnt - t0), 32'd403);
    check_oam(8'hD0, "r_oam");
    chk("r_ff46", 32'(d), 32'hD0);
`else
    chk("r_active_cycles", 32'(act_cnt - t0), 32'd321);
    check_oam(8'hC1, "r_oam");
    chk("r_ff46", 32'(d), 32'hC1);
`endif

    // Reset in the middle of a transfer, at byte 50.
    clear_oam();
    cpu_write(16'hFF46, 8'hC1);
    wait_read(16'hC132, "m_wait_byte50");
    cpu_addr = 16'h1234; cpu_re = 1'b1;
    rst = 1'b0;
    #1;
    chk("m_mem_re", 32'(mem_re), 32'd0);
    chk("m_mem_we", 32'(mem_we), 32'd0);
    chk("m_mem_addr", 32'(mem_addr), 32'd0);
    chk("m_dma_active", 32'(dma_active), 32'd0);
    cpu_re = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cpu_read(16'hFF46, d);
    chk("m_ff46", 32'(d), 32'h00);
    chk("m_active_after", 32'(dma_active), 32'd0);
    @(negedge clk);
    cpu_addr = 16'hC000; cpu_re = 1'b1;
    #1 chk("m_idle_fwd", 32'(mem_re), 32'd1);
    cpu_re = 1'b0;
    chk("m_oam_49", 32'(mem_arr[16'hFE31]), 32'(8'd49 ^ 8'h5A));
    chk("m_oam_50", 32'(mem_arr[16'hFE32]), 32'h00);

    @(negedge clk);
    chk("bus_invariants", 32'(viol_cnt), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the shared memory bus between the CPU datapath and the OAM DMA engine.
- Decodes the DMA register at 0xFF46. When the CPU writes it, the block copies 160 bytes from {src,8'h00} to OAM at 0xFE00, one read cycle and one write cycle per byte.
- While DMA runs, the CPU is locked out of the external bus. CPU accesses to HRAM (0xFF80–0xFFFE) go to a dedicated HRAM port and always proceed.
- Sits between the datapath's MAR/MDR memory interface and the memory map.

Parameters:
- OAM_LEN, 160, number of bytes copied per DMA.
- START_DELAY, 1, idle cycles between the FF46 write and the first DMA read (0..3).
- LOCKOUT_RDATA, 8'hFF, value returned to CPU reads that are blocked during DMA.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- cpu_addr  in  16  CPU address (MAR).
- cpu_wdata  in  8  CPU write data (MDR).
- cpu_re  in  1  CPU read strobe.
- cpu_we  in  1  CPU write strobe.
- cpu_rdata  out  8  read data to CPU, combinational.
- mem_addr  out  16  external bus address.
- mem_wdata  out  8  external bus write data.
- mem_re  out  1  external bus read.
- mem_we  out  1  external bus write.
- mem_rdata  in  8  external bus read data, valid in the same cycle (asynchronous memory).
- hram_addr  out  7  HRAM offset (cpu_addr[6:0]).
- hram_wdata  out  8  HRAM write data.
- hram_we  out  1  HRAM write.
- hram_rdata  in  8  HRAM read data, combinational.
- dma_active  out  1  high from FF46 write acceptance until the last OAM write completes.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; src_reg = 8'h00; byte_idx = 0; buf = 8'h00; delay counter = 0.
  - mem_re, mem_we, hram_we and dma_active = 0; mem_addr = 0; mem_wdata = 0.
  - Reset asserted mid-DMA aborts the transfer immediately. Partially written OAM is left as is.
- Address decode:
  - HRAM region: 0xFF80–0xFFFE.
  - DMA register: 0xFF46.
  - All other addresses: external bus.
- FF46 write in IDLE:
  - src_reg <= cpu_wdata on the clock edge; state -> START; dma_active = 1 from the next cycle.
  - The write is not forwarded to mem_*.
- FF46 read: cpu_rdata = src_reg in every state.
- Source mapping: if src_reg >= 8'hE0, the effective source high byte is src_reg - 8'h20 (echo RAM). Otherwise the source is src_reg unchanged.
- State machine:
  - IDLE: CPU owns the bus; mem_* = cpu_*.
  - START: waits START_DELAY cycles, then -> READ. If START_DELAY = 0, goes straight to READ next cycle.
  - READ: mem_addr = {eff_src, byte_idx}; mem_re = 1; buf <= mem_rdata at the edge; -> WRITE.
  - WRITE: mem_addr = 16'hFE00 + byte_idx; mem_we = 1; mem_wdata = buf. If byte_idx == OAM_LEN-1: byte_idx <= 0, -> IDLE. Otherwise byte_idx++ and -> READ.
- Latency: the first OAM write occurs START_DELAY+2 cycles after the FF46 write edge. Total dma_active time = START_DELAY + 2*OAM_LEN cycles (321 with defaults).
- CPU access while state != IDLE:
  - HRAM accesses are routed normally.
  - Other reads return LOCKOUT_RDATA; other writes are dropped (never reach mem_*).
  - FF46 writes follow the Optional Feature rule.
- HRAM routing is independent of state: hram_we = cpu_we & hram_hit; cpu_rdata = hram_rdata on an HRAM hit.
- The CPU and DMA never drive mem_re or mem_we in the same cycle. mem_re and mem_we are never both high.
- A cpu_re and cpu_we asserted together are treated as a write.

Optional Feature:
- Macro: OAM_DMA_RESTART_EN.
- When defined: an FF46 write in START, READ or WRITE does the following:
  - reloads src_reg and clears byte_idx;
  - sends state -> START;
  - keeps dma_active high;
  - discards any in-flight buf.
- When undefined: an FF46 write during DMA is ignored entirely, and src_reg is unchanged.

Decomposition:
- Package gb_mem_pkg holds:
  - dma_state_t enum (IDLE, START, READ, WRITE);
  - constants DMA_REG_ADDR = 16'hFF46, OAM_BASE = 16'hFE00, HRAM_LO = 16'hFF80, HRAM_HI = 16'hFFFE;
  - region_t enum (REG_EXT, REG_HRAM, REG_DMA).
- One sub-module, mem_region_decode: a purely combinational cpu_addr -> region_t decoder, reused later by the PPU/IO blocks.

Test Plan:
- Reset mid-DMA (drop rst at byte 50) -> outputs zero asynchronously, state IDLE; after release, FF46 reads 8'h00.
- CPU writes 8'hC1 to FF46 with src memory C100+i = i ^ 8'h5A -> OAM FE00+i = i ^ 8'h5A for i = 0..159; dma_active high exactly 321 cycles; FF46 reads 8'hC1.
- During DMA, CPU writes 8'h77 to FF90 and reads it back -> hram_we pulses, read returns 8'h77. CPU reads C000 -> 8'hFF with no mem_re from the CPU. CPU writes C000 -> no mem_we outside DMA WRITE states.
- FF46 = 8'hE2 -> reads are issued at C200..C29F.
- FF46 = 8'hC1, then 8'hD0 at byte 40:
  - with OAM_DMA_RESTART_EN: OAM holds D000.. data for all 160 bytes, and dma_active lasts 40*2 + 2 + 321 cycles total from the first write;
  - without it: OAM holds C100.. data, and FF46 reads 8'hC1.
- Every cycle, assert !(mem_re && mem_we), and assert no mem_we hits the 0xFF80–0xFFFE range.
